// File: rtl/bram_stream_reader.sv
// bram_stream_reader: read-side sequencer for a single-clock simple dual-port BRAM.
// Drives enb/addrb for a (base, len) request, captures the registered dob output
// into a 4-entry FIFO and presents it as a valid/ready stream with last marking.
// Read issue is credit based (FIFO occupancy + in-flight read), so the FIFO can
// never overflow regardless of downstream backpressure.
module bram_stream_reader #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state_q, state_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;           // reads still to be issued
  logic                  inflight_q;      // read issued last cycle, data on dob now
  logic                  inflight_last_q; // that read is the final one of the transfer
  entry_t                fifo_q [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            count_q;

  logic                  accept;
  logic                  credit_ok;
  logic                  issue;
  logic                  last_issue;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] addr_next;
  entry_t                head;

  // A pop in the same cycle is deliberately not credited: keeps the credit
  // check a pure function of registered state.
  assign credit_ok  = (count_q + {2'b00, inflight_q}) < 3'd4;
  assign issue      = (state_q == RUN) && credit_ok;
  assign last_issue = issue && (rem_q == LEN_WIDTH'(1));
  assign accept     = (state_q == IDLE) && start && (len != '0);
  assign push       = inflight_q;
  assign pop        = (count_q != 3'd0) && m_ready;
  assign head       = fifo_q[rd_ptr_q];

  // Explicit compare so a non-power-of-two DEPTH wraps correctly.
  assign addr_next = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  assign enb     = issue;
  assign addrb   = addr_q;
  assign m_valid = (count_q != 3'd0);
  assign m_data  = head.data;
  assign m_last  = m_valid && head.last;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  // State and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next state: a zero-length request completes immediately without reads;
  // DRAIN ends on the handshake of the beat tagged last, which by construction
  // is the final entry in the FIFO with nothing left in flight.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) state_d = RUN;
          else           done_d  = 1'b1;
        end
      end
      RUN: begin
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read address/remaining counter and the one-deep read pipeline tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= base_addr;
        rem_q  <= len;
      end else if (issue) begin
        addr_q <= addr_next;
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  // FIFO storage and pointers; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{last: inflight_last_q, data: dob};
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
